// File: rtl/regfile.sv
// Integer register file / write-back endpoint: two combinational read ports with WB bypass,
// plus a req/ack debug port (2-state FSM) that yields to write-back on contention.
module regfile #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_we_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic [DW-1:0] rd_data_i,
  input  logic [AW-1:0] rs1_addr_i,
  output logic [DW-1:0] rs1_data_o,
  input  logic [AW-1:0] rs2_addr_i,
  output logic [DW-1:0] rs2_data_o,
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic [DW-1:0] dbg_wdata_i,
  output logic          dbg_ack_o,
  output logic [DW-1:0] dbg_rdata_o
);

  localparam int NREG = 1 << AW;

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] mem [NREG];
  logic          wb_wr;
  logic          dbg_rd_acc;
  logic          dbg_wr_acc;
  logic [DW-1:0] dbg_rd_val;

  // Entry 0 is never written, so a stored read of x0 already yields zero.
  assign wb_wr = rd_we_i && (rd_addr_i != '0);

  always_comb begin
    rs1_data_o = mem[rs1_addr_i];
    if (!rst_n || rs1_addr_i == '0)
      rs1_data_o = '0;
    else if (wb_wr && rd_addr_i == rs1_addr_i)
      rs1_data_o = rd_data_i;
  end

  always_comb begin
    rs2_data_o = mem[rs2_addr_i];
    if (!rst_n || rs2_addr_i == '0)
      rs2_data_o = '0;
    else if (wb_wr && rd_addr_i == rs2_addr_i)
      rs2_data_o = rd_data_i;
  end

  always_comb begin
    dbg_rd_val = mem[dbg_addr_i];
    if (dbg_addr_i == '0)
      dbg_rd_val = '0;
    else if (wb_wr && rd_addr_i == dbg_addr_i)
      dbg_rd_val = rd_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      dbg_rdata_o <= '0;
    end else begin
      state <= state_nxt;
      if (dbg_rd_acc)
        dbg_rdata_o <= dbg_rd_val;
    end
  end

  // Debug writes stall on any WB enable, even one aimed at x0.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dbg_req_i && (!dbg_we_i || !rd_we_i)) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dbg_rd_acc = (state == IDLE) && dbg_req_i && !dbg_we_i;
    dbg_wr_acc = (state == IDLE) && dbg_req_i && dbg_we_i && !rd_we_i;
    dbg_ack_o  = (state == ACK);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        mem[i] <= '0;
    end else if (wb_wr) begin
      mem[rd_addr_i] <= rd_data_i;
    end else if (dbg_wr_acc && dbg_addr_i != '0) begin
      mem[dbg_addr_i] <= dbg_wdata_i;
    end
  end

endmodule
